fdtd_buf_reader: RTL and testbench
==================================

# fdtd_buf_reader

Read-side sequencer for the FDTD line buffer RAM. On a start command it walks a contiguous, wrap-around address range of the buffer through the buffer's combinational read port. It registers each word and streams it out on a valid/ready interface toward the FDTD update datapath, flagging the last word and pulsing done on completion.

## Interface
- FDTD_DATA_WIDTH, 32, width of one buffer word
- BUFFER_ADDR_WIDTH, 6, buffer address width; depth = 2**BUFFER_ADDR_WIDTH

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- start  in  1  command pulse; sampled only while busy=0
- base_addr  in  BUFFER_ADDR_WIDTH  first address of the transfer
- len  in  BUFFER_ADDR_WIDTH+1  word count, 1..2**BUFFER_ADDR_WIDTH
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after the final word handshake
- ram_rden  out  1  buffer read enable
- ram_addr  out  BUFFER_ADDR_WIDTH  buffer read address
- ram_dout  in  FDTD_DATA_WIDTH  buffer read data, combinational from ram_addr/ram_rden
- m_valid  out  1  stream word valid
- m_ready  in  1  downstream accept
- m_data  out  FDTD_DATA_WIDTH  stream word
- m_last  out  1  marks final word of transfer

## Operation
- States: IDLE, RUN (words remain to fetch), DRAIN (all fetched, last word not yet accepted).
- IDLE:
  - start=1 with len≠0 latches base_addr into the fetch pointer and len into the remaining counter, then goes to RUN.
  - start with len=0 is ignored: stay IDLE, no done.
  - len > 2**BUFFER_ADDR_WIDTH is clamped to 2**BUFFER_ADDR_WIDTH.
- Fetch condition: state RUN and (m_valid=0 or m_ready=1).
  - On fetch: ram_rden=1, ram_addr=fetch pointer; ram_dout is captured into m_data and m_valid=1 at the next edge.
  - Pointer increments modulo 2**BUFFER_ADDR_WIDTH; 2**BUFFER_ADDR_WIDTH-1 wraps to 0.
  - Remaining counter decrements.
- The fetch of the final word sets m_last with that word and moves RUN→DRAIN.
- DRAIN: no fetches. The handshake with m_valid&m_ready&m_last clears m_valid and m_last, goes to IDLE and pulses done for one cycle.
- m_data and m_last are stable while m_valid=1 and m_ready=0. m_valid never drops without a handshake.
- ram_rden=0 in every non-fetch cycle. ram_addr always shows the fetch pointer register.
- busy=1 exactly in RUN and DRAIN.
- start while busy=1 is ignored.
- Reset values: busy=0, done=0, ram_rden=0, ram_addr=0, m_valid=0, m_data=0, m_last=0, state IDLE.
- Reset mid-transfer abandons the stream immediately, with no done and no m_last.

## Timing
- Start sampled at edge 0 → busy=1 and first ram_rden in cycle 1 → m_valid with word base_addr in cycle 2.
- With m_ready held high the throughput is one word per cycle. The last word is valid in cycle len+1. In cycle len+2, done=1 and busy=0.
- A new start is accepted in the done cycle; its first fetch follows in the next cycle.
- m_ready low stalls the fetch in the same cycle. Fetching resumes in the cycle m_ready is seen high while m_valid=1, so there are no bubbles and no lost words.
- done and m_valid are never high in the same cycle.

## Structure
- Shared package fdtd_pkg holds the reader state enum typedef (IDLE/RUN/DRAIN) and the common FDTD_DATA_WIDTH / BUFFER_ADDR_WIDTH defaults.
- One natural sub-module: fdtd_stream_reg, the one-entry output register holding m_valid, m_data and m_last, with a load/accept interface.
- The top level holds the FSM, the fetch pointer and the remaining counter.

## Test plan
- RAM preloaded with addr*3. start, base=4, len=5, m_ready=1 → m_data 12,15,18,21,24 in cycles 2..6; m_last only on 24; done in cycle 7; exactly 5 ram_rden cycles.
- Wrap: base=62, len=4 → addresses 62,63,0,1 in order, m_last on address 1.
- Backpressure: len=6, m_ready toggling 1,0,0,1 repeated → all 6 words delivered once, in order, data stable during stalls, ram_rden never high while m_valid=1 and m_ready=0.
- Commands ignored: start with len=0 → busy stays 0, no done. Second start during busy with a different base → first transfer unaffected.
- Full depth: len=64, base=10 → 64 words ending at address 9. A back-to-back start in the done cycle streams its first word two cycles later.
- RST asserted in the middle of a len=8 transfer → all outputs at reset values immediately. A next start with base=0, len=2 works normally.

Source files
------------

// File: rtl/fdtd_pkg.sv
// Shared definitions for the FDTD line-buffer reader: default widths and reader state encoding.
package fdtd_pkg;

   localparam int unsigned FDTD_DATA_WIDTH   = 32;
   localparam int unsigned BUFFER_ADDR_WIDTH = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

endpackage

// File: rtl/fdtd_stream_reg.sv
// One-entry output register for the read stream; loads a word and holds it until it is accepted.
module fdtd_stream_reg
   import fdtd_pkg::*;
#(
   parameter int unsigned DW = fdtd_pkg::FDTD_DATA_WIDTH
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          load_last,
   input  logic          accept,
   output logic          valid,
   output logic [DW-1:0] data,
   output logic          last
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;
   logic          last_q, last_d;

   // Load takes priority: the producer only loads when the slot is empty or being emptied.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
         last_d  = load_last;
      end else if (valid_q && accept) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;
   assign last  = last_q;

endmodule

// File: rtl/fdtd_buf_reader.sv
// Read-side sequencer for the FDTD line buffer: walks a wrap-around address range and
// streams the words out through a one-entry register with valid/ready flow control.
module fdtd_buf_reader
   import fdtd_pkg::*;
#(
   parameter int unsigned FDTD_DATA_WIDTH   = fdtd_pkg::FDTD_DATA_WIDTH,
   parameter int unsigned BUFFER_ADDR_WIDTH = fdtd_pkg::BUFFER_ADDR_WIDTH
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         start,
   input  logic [BUFFER_ADDR_WIDTH-1:0] base_addr,
   input  logic [BUFFER_ADDR_WIDTH:0]   len,
   output logic                         busy,
   output logic                         done,
   output logic                         ram_rden,
   output logic [BUFFER_ADDR_WIDTH-1:0] ram_addr,
   input  logic [FDTD_DATA_WIDTH-1:0]   ram_dout,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [FDTD_DATA_WIDTH-1:0]   m_data,
   output logic                         m_last
);

   localparam int unsigned AW    = BUFFER_ADDR_WIDTH;
   localparam int unsigned LW    = BUFFER_ADDR_WIDTH + 1;
   localparam int unsigned DEPTH = 2 ** BUFFER_ADDR_WIDTH;

   rd_state_e     state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [LW-1:0] rem_q, rem_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          fetch_c;
   logic          last_fetch_c;
   logic          last_hs_c;
   logic [LW-1:0] len_eff_c;

   assign len_eff_c = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
   assign last_hs_c = m_valid && m_ready && m_last;

   // Next-state logic; a fetch happens whenever the output slot is free or being drained.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      rem_d        = rem_q;
      done_d       = 1'b0;
      fetch_c      = 1'b0;
      last_fetch_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && (len != '0)) begin
               ptr_d   = base_addr;
               rem_d   = len_eff_c;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!m_valid || m_ready) begin
               fetch_c = 1'b1;
               ptr_d   = ptr_q + AW'(1);
               rem_d   = rem_q - LW'(1);
               if (rem_q == LW'(1)) begin
                  last_fetch_c = 1'b1;
                  state_d      = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (last_hs_c) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign ram_rden = fetch_c;
   assign ram_addr = ptr_q;

   fdtd_stream_reg #(
      .DW(FDTD_DATA_WIDTH)
   ) u_stream_reg (
      .CLK       (CLK),
      .RST       (RST),
      .load      (fetch_c),
      .load_data (ram_dout),
      .load_last (last_fetch_c),
      .accept    (m_ready),
      .valid     (m_valid),
      .data      (m_data),
      .last      (m_last)
   );

endmodule

// File: tb/tb_fdtd_buf_reader.sv
// Scoreboard bench for fdtd_buf_reader: a RAM model, a transfer-level reference and a negedge monitor.
module tb_fdtd_buf_reader;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 64;

   logic          CLK;
   logic          RST;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic          ram_rden;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_dout;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;

   fdtd_buf_reader dut (
      .CLK       (CLK),
      .RST       (RST),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .ram_rden  (ram_rden),
      .ram_addr  (ram_addr),
      .ram_dout  (ram_dout),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [DW-1:0] mem [DEPTH];
   always_comb ram_dout = ram_rden ? mem[ram_addr] : '0;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   exp_t          sb[$];
   int            tests;
   int            fails;
   int            rden_cnt;
   logic          busy_exp;
   logic          done_exp;
   logic          prev_stall;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   int            rmode;
   int            pidx;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Expected words for an accepted command are pushed here; ignored commands push nothing.
   task automatic issue_start(input int b, input int l);
      int n;
      start     = 1'b1;
      base_addr = AW'(b);
      len       = 7'(l);
      if (!busy_exp && l != 0) begin
         n        = (l > int'(DEPTH)) ? int'(DEPTH) : l;
         rden_cnt = 0;
         for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data = mem[(b + i) % DEPTH];
            e.last = (i == n - 1);
            sb.push_back(e);
         end
      end
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int limit, input string name);
      int c;
      c = 0;
      while ((busy_exp || sb.size() != 0) && c < limit) begin
         tick();
         c++;
      end
      if (c >= limit) begin
         tests++;
         fails++;
         $display("FAIL timeout %s: %0d words outstanding after %0d cycles", name, sb.size(), c);
         sb.delete();
      end
      tick();
      tick();
   endtask

   // m_ready driver: 0 = always high, 1 = pattern 1,0,0,1, 2 = random.
   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         case (rmode)
            0:       m_ready = 1'b1;
            1:       begin m_ready = (pidx % 4 == 0) || (pidx % 4 == 3); pidx++; end
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: checks every handshake against the scoreboard plus the cycle-level rules.
   always @(negedge CLK) begin
      if (!RST) begin
         chk("busy", 64'(busy), 64'(busy_exp));
         chk("done", 64'(done), 64'(done_exp));
         if (done) chk("done_with_valid", 64'(m_valid), 64'd0);
         if (prev_stall) begin
            chk("stall_valid", 64'(m_valid), 64'd1);
            chk("stall_data", 64'(m_data), 64'(prev_data));
            chk("stall_last", 64'(m_last), 64'(prev_last));
         end
         if (m_valid && !m_ready) chk("rden_in_stall", 64'(ram_rden), 64'd0);
         if (!busy_exp) chk("rden_idle", 64'(ram_rden), 64'd0);
         if (ram_rden) rden_cnt++;
         if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_word: got data %0h last %0b with nothing expected", m_data, m_last);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("data", 64'(m_data), 64'(e.data));
               chk("last", 64'(m_last), 64'(e.last));
            end
         end
         done_exp = m_valid && m_ready && m_last;
         if (!busy_exp) begin
            if (start && len != '0) busy_exp = 1'b1;
         end else if (m_valid && m_ready && m_last) begin
            busy_exp = 1'b0;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      tests      = 0;
      fails      = 0;
      rden_cnt   = 0;
      busy_exp   = 1'b0;
      done_exp   = 1'b0;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      rmode      = 0;
      pidx       = 0;
      start      = 1'b0;
      base_addr  = '0;
      len        = '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i * 3);
      RST = 1'b0;
      #1 RST = 1'b1;
      #3;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rden", 64'(ram_rden), 64'd0);
      chk("rst_addr", 64'(ram_addr), 64'd0);
      chk("rst_valid", 64'(m_valid), 64'd0);
      chk("rst_data", 64'(m_data), 64'd0);
      chk("rst_last", 64'(m_last), 64'd0);
      tick();
      RST = 1'b0;
      tick();

      // Basic transfer with timing: base 4, len 5, ready held high.
      issue_start(4, 5);
      chk("t1_busy_c1", 64'(busy), 64'd1);
      chk("t1_rden_c1", 64'(ram_rden), 64'd1);
      tick();
      chk("t1_valid_c2", 64'(m_valid), 64'd1);
      chk("t1_data_c2", 64'(m_data), 64'd12);
      c = 2;
      while (!done && c < 20) begin
         tick();
         c++;
      end
      chk("t1_done_cycle", 64'(c), 64'd7);
      chk("t1_busy_done", 64'(busy), 64'd0);
      chk("t1_rden_count", 64'(rden_cnt), 64'd5);
      wait_idle(50, "t1");

      // Wrap-around: 62,63,0,1.
      issue_start(62, 4);
      wait_idle(50, "wrap");
      chk("wrap_rden_count", 64'(rden_cnt), 64'd4);

      // Backpressure with the 1,0,0,1 ready pattern.
      rmode = 1;
      pidx  = 0;
      issue_start(30, 6);
      wait_idle(100, "bp");
      chk("bp_rden_count", 64'(rden_cnt), 64'd6);
      rmode = 0;
      tick();

      // Ignored commands: len=0, then a start while busy.
      issue_start(5, 0);
      repeat (3) tick();
      chk("len0_busy", 64'(busy), 64'd0);
      issue_start(20, 3);
      issue_start(40, 5);
      wait_idle(50, "busy_start");
      chk("busy_start_rden", 64'(rden_cnt), 64'd3);

      // Full depth, then a back-to-back start in the done cycle.
      issue_start(10, 64);
      c = 0;
      while (!done && c < 200) begin
         tick();
         c++;
      end
      chk("full_done_seen", 64'(done), 64'd1);
      chk("full_rden_count", 64'(rden_cnt), 64'd64);
      issue_start(33, 3);
      tick();
      chk("b2b_valid", 64'(m_valid), 64'd1);
      chk("b2b_data", 64'(m_data), 64'(mem[33]));
      wait_idle(50, "b2b");

      // Reset in the middle of a transfer.
      issue_start(50, 8);
      repeat (3) tick();
      #2 RST = 1'b1;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_rden", 64'(ram_rden), 64'd0);
      chk("mid_rst_addr", 64'(ram_addr), 64'd0);
      chk("mid_rst_valid", 64'(m_valid), 64'd0);
      chk("mid_rst_data", 64'(m_data), 64'd0);
      chk("mid_rst_last", 64'(m_last), 64'd0);
      sb.delete();
      busy_exp   = 1'b0;
      done_exp   = 1'b0;
      prev_stall = 1'b0;
      tick();
      RST = 1'b0;
      tick();
      issue_start(0, 2);
      wait_idle(50, "post_rst");
      chk("post_rst_rden", 64'(rden_cnt), 64'd2);

      // Randomized transfers: random contents, base, length, ready behaviour and stray starts.
      for (int k = 0; k < 40; k++) begin
         int b;
         int l;
         int sel;
         for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
         rmode = int'($urandom_range(0, 2));
         b     = int'($urandom_range(0, DEPTH - 1));
         sel   = int'($urandom_range(0, 7));
         if (sel == 0)      l = 0;
         else if (sel == 1) l = int'($urandom_range(65, 127));
         else               l = int'($urandom_range(1, 64));
         issue_start(b, l);
         if ($urandom_range(0, 1) == 1) begin
            repeat (int'($urandom_range(0, 3))) tick();
            issue_start(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 64)));
         end
         wait_idle(2000, "random");
      end
      rmode = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
